clock_mode_ctrl: RTL and testbench

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

---
 rtl/clock_mode_ctrl_if.sv | 24 ++
 rtl/clock_mode_ctrl.sv | 143 ++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clock_mode_ctrl_if.sv
// Button/tick inputs and registered control outputs of the watch mode controller.
// The master side drives buttons and the 1 Hz tick; the slave side is the controller.
interface clock_mode_ctrl_if;
  logic       enb;
  logic [3:0] btn;
  logic [2:0] mode;
  logic       inc_hour;
  logic       inc_min;
  logic       sel_alarm;
  logic       time_hold;
  logic       sw_toggle;
  logic       sw_clear;
  logic       blink;

  modport master (
    output enb, btn,
    input  mode, inc_hour, inc_min, sel_alarm, time_hold, sw_toggle, sw_clear, blink
  );

  modport slave (
    input  enb, btn,
    output mode, inc_hour, inc_min, sel_alarm, time_hold, sw_toggle, sw_clear, blink
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Watch mode controller: turns button presses into state changes and one-cycle strobes,
// with an idle timeout that drops the set states back to NORMAL.
module clock_mode_ctrl #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_mode_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    SET_TIME_H = 3'd1,
    SET_TIME_M = 3'd2,
    SET_ALM_H  = 3'd3,
    SET_ALM_M  = 3'd4,
    STOPWATCH  = 3'd5
  } state_t;

  localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT_SEC);

  state_t     state;
  state_t     next_state;
  logic [3:0] btn_prev;
  logic [3:0] rise;
  logic [4:0] idle_cnt;
  logic [4:0] next_idle;
  logic       next_blink;
  logic       press_back;
  logic       press_mode;
  logic       press_inc;
  logic       press_clear;
  logic       in_set;
  logic       next_in_set;
  logic       accepted;
  logic       req_hour;
  logic       req_min;
  logic       req_toggle;
  logic       req_clear;

  // Only the highest-priority rising edge survives; the rest are dropped.
  assign rise        = bus.btn & ~btn_prev;
  assign press_back  = rise[2];
  assign press_mode  = rise[0] & ~rise[2];
  assign press_inc   = rise[1] & ~rise[2] & ~rise[0];
  assign press_clear = rise[3] & ~rise[2] & ~rise[0] & ~rise[1];

  assign in_set      = (state == SET_TIME_H) || (state == SET_TIME_M) ||
                       (state == SET_ALM_H)  || (state == SET_ALM_M);
  assign next_in_set = (next_state == SET_TIME_H) || (next_state == SET_TIME_M) ||
                       (next_state == SET_ALM_H)  || (next_state == SET_ALM_M);

  assign accepted = in_set & (press_back | press_mode | press_inc);

  always_comb begin
    next_state = state;
    req_hour   = 1'b0;
    req_min    = 1'b0;
    req_toggle = 1'b0;
    req_clear  = 1'b0;
    case (state)
      NORMAL: begin
        if (press_mode) next_state = SET_TIME_H;
      end
      SET_TIME_H: begin
        if (press_back)      next_state = NORMAL;
        else if (press_mode) next_state = SET_TIME_M;
        else if (press_inc)  req_hour = 1'b1;
      end
      SET_TIME_M: begin
        if (press_back)      next_state = NORMAL;
        else if (press_mode) next_state = SET_ALM_H;
        else if (press_inc)  req_min = 1'b1;
      end
      SET_ALM_H: begin
        if (press_back)      next_state = NORMAL;
        else if (press_mode) next_state = SET_ALM_M;
        else if (press_inc)  req_hour = 1'b1;
      end
      SET_ALM_M: begin
        if (press_back)      next_state = NORMAL;
        else if (press_mode) next_state = STOPWATCH;
        else if (press_inc)  req_min = 1'b1;
      end
      STOPWATCH: begin
        if (press_back || press_mode) next_state = NORMAL;
        else if (press_inc)           req_toggle = 1'b1;
        else if (press_clear)         req_clear = 1'b1;
      end
      default: next_state = NORMAL;
    endcase

    // A press in the same cycle as the final tick wins, since accepted blocks the timeout.
    if (in_set && !accepted && bus.enb && (idle_cnt + 5'd1 == TIMEOUT_LIM))
      next_state = NORMAL;
  end

  always_comb begin
    next_idle  = idle_cnt;
    next_blink = bus.blink;
    if (!next_in_set || next_state != state || accepted)
      next_idle = 5'd0;
    else if (bus.enb)
      next_idle = idle_cnt + 5'd1;

    if (!next_in_set)
      next_blink = 1'b0;
    else if (next_state != state)
      next_blink = 1'b1;
    else if (bus.enb)
      next_blink = ~bus.blink;
  end

  // Priming btn_prev with all ones keeps a button held through reset from counting as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= NORMAL;
      btn_prev      <= 4'b1111;
      idle_cnt      <= 5'd0;
      bus.inc_hour  <= 1'b0;
      bus.inc_min   <= 1'b0;
      bus.sw_toggle <= 1'b0;
      bus.sw_clear  <= 1'b0;
      bus.sel_alarm <= 1'b0;
      bus.time_hold <= 1'b0;
      bus.blink     <= 1'b0;
    end else begin
      state         <= next_state;
      btn_prev      <= bus.btn;
      idle_cnt      <= next_idle;
      bus.inc_hour  <= req_hour;
      bus.inc_min   <= req_min;
      bus.sw_toggle <= req_toggle;
      bus.sw_clear  <= req_clear;
      bus.sel_alarm <= (next_state == SET_ALM_H) || (next_state == SET_ALM_M);
      bus.time_hold <= (next_state == SET_TIME_H) || (next_state == SET_TIME_M);
      bus.blink     <= next_blink;
    end
  end

  assign bus.mode = state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomized and directed bench for clock_mode_ctrl against a cycle-level behavioural model.
module tb_clock_mode_ctrl;
  localparam int TIMEOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(.TIMEOUT_SEC(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: mode as a plain number walking round a 6-entry ring.
  int       m_mode  = 0;
  int       m_idle  = 0;
  bit       m_blink = 0;
  bit [3:0] m_prev  = 4'b1111;
  bit       m_hour, m_min, m_tog, m_clr;

  function automatic bit isSet(int m);
    return (m >= 1) && (m <= 4);
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit [3:0] b, input bit e);
    bit [3:0] rise;
    int       old;
    bit       acted;
    m_hour = 0; m_min = 0; m_tog = 0; m_clr = 0;
    if (r) begin
      m_mode = 0; m_idle = 0; m_blink = 0; m_prev = 4'b1111;
      return;
    end
    rise   = b & ~m_prev;
    m_prev = b;
    old    = m_mode;
    acted  = 0;
    if (rise[2]) begin
      m_mode = 0; acted = 1;
    end else if (rise[0]) begin
      m_mode = (m_mode + 1) % 6; acted = 1;
    end else if (rise[1]) begin
      acted = 1;
      if (m_mode == 1 || m_mode == 3) m_hour = 1;
      else if (m_mode == 2 || m_mode == 4) m_min = 1;
      else if (m_mode == 5) m_tog = 1;
    end else if (rise[3]) begin
      if (m_mode == 5) m_clr = 1;
    end
    if (isSet(old)) begin
      if (acted) m_idle = 0;
      else if (e) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_mode = 0;
      end
    end
    if (!isSet(m_mode) || m_mode != old) m_idle = 0;
    if (!isSet(m_mode))   m_blink = 0;
    else if (m_mode != old) m_blink = 1;
    else if (e)           m_blink = ~m_blink;
  endtask

  task automatic applyStimulus(input bit r, input bit [3:0] b, input bit e);
    rst     = r;
    bus.btn = b;
    bus.enb = e;
    @(posedge clk);
    modelStep(r, b, e);
    #1;
    checkOutput("mode",      int'(bus.mode),      m_mode);
    checkOutput("inc_hour",  int'(bus.inc_hour),  int'(m_hour));
    checkOutput("inc_min",   int'(bus.inc_min),   int'(m_min));
    checkOutput("sw_toggle", int'(bus.sw_toggle), int'(m_tog));
    checkOutput("sw_clear",  int'(bus.sw_clear),  int'(m_clr));
    checkOutput("sel_alarm", int'(bus.sel_alarm), int'(m_mode == 3 || m_mode == 4));
    checkOutput("time_hold", int'(bus.time_hold), int'(m_mode == 1 || m_mode == 2));
    checkOutput("blink",     int'(bus.blink),     int'(m_blink));
  endtask

  task automatic press(input bit [3:0] b);
    applyStimulus(0, b, 0);
    applyStimulus(0, 4'b0000, 0);
  endtask

  task automatic doReset();
    applyStimulus(1, 4'b0000, 0);
    applyStimulus(0, 4'b0000, 0);
  endtask

  initial begin
    bit [3:0] b;
    bus.btn = 4'b0000;
    bus.enb = 1'b0;

    $display("[TB] reset and MODE ring");
    doReset();
    for (int i = 0; i < 6; i++) press(4'b0001);

    $display("[TB] INC in SET_TIME_M");
    doReset();
    press(4'b0001);
    press(4'b0001);
    for (int i = 0; i < 3; i++) press(4'b0010);

    $display("[TB] idle timeout in SET_ALM_H");
    doReset();
    for (int i = 0; i < 3; i++) press(4'b0001);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(0, 4'b0000, 1);
      applyStimulus(0, 4'b0000, 0);
    end
    checkOutput("timeout_mode", int'(bus.mode), 0);
    for (int i = 0; i < 3; i++) press(4'b0001);
    for (int t = 1; t <= 19; t++) begin
      applyStimulus(0, (t == 9) ? 4'b0010 : 4'b0000, 1);
      if (t == 18) checkOutput("still_set", int'(bus.mode), 3);
      applyStimulus(0, 4'b0000, 0);
    end
    checkOutput("late_timeout", int'(bus.mode), 0);

    $display("[TB] simultaneous presses in STOPWATCH");
    doReset();
    for (int i = 0; i < 5; i++) press(4'b0001);
    press(4'b1110);

    $display("[TB] MODE held through reset");
    applyStimulus(1, 4'b0001, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0001, 0);
    press(4'b0001);

    $display("[TB] reset in SET_TIME_H");
    doReset();
    press(4'b0001);
    applyStimulus(1, 4'b0000, 0);

    $display("[TB] random busy traffic");
    b = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) b[k] = ~b[k];
      applyStimulus($urandom_range(0, 199) == 0, b, $urandom_range(0, 2) == 0);
    end

    $display("[TB] random sparse traffic");
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 63) == 0) b[k] = ~b[k];
      applyStimulus($urandom_range(0, 999) == 0, b, $urandom_range(0, 1) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
